// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with shadowed, glitch-free runtime retuning.
// Optional CLKDIV_STROBE_EN adds a one-cycle per-channel strobe at each period start.
module clk_div_multi #(
   parameter int CH      = 4,
   parameter int W       = 32,
   parameter int CHW     = 2,
   parameter int DEF_DIV = 1000
) (
   input  logic            clk,
   input  logic            phase_rst,
   input  logic            sync_rst,
   input  logic [CH-1:0]   ch_en,
   input  logic            cfg_valid,
   output logic            cfg_ready,
   input  logic [CHW-1:0]  cfg_ch,
   input  logic [W-1:0]    cfg_div,
   input  logic [W-1:0]    cfg_high,
   input  logic [W-1:0]    cfg_phase,
   output logic            cfg_err,
   output logic [CH-1:0]   clk_div,
   output logic [CH*W-1:0] cnt
`ifdef CLKDIV_STROBE_EN
   ,
   output logic [CH-1:0]   strobe
`endif
);

   localparam int NSEL = 2**CHW;
   localparam logic [W-1:0] RST_DIV  = W'(DEF_DIV);
   localparam logic [W-1:0] RST_HIGH = W'((DEF_DIV + 1) >> 1);

   logic [CH-1:0]   pending;
   logic [NSEL-1:0] busy_sel;
   logic            xfer;
   logic            cfg_ok;
   logic            accept;

   // Channel numbers beyond CH read as busy, so writes to them are never accepted.
   assign busy_sel  = ~NSEL'(~pending);
   assign cfg_ready = ~busy_sel[cfg_ch];
   assign xfer      = cfg_valid & cfg_ready;
   assign cfg_ok    = (cfg_div >= W'(2)) && (cfg_high >= W'(1)) &&
                      (cfg_high < cfg_div) && (cfg_phase < cfg_div);
   assign accept    = xfer & cfg_ok;

   always_ff @(posedge clk or posedge phase_rst) begin
      if (phase_rst) cfg_err <= 1'b0;
      else           cfg_err <= xfer & ~cfg_ok;
   end

   for (genvar i = 0; i < CH; i++) begin : g_ch
      logic [W-1:0] div_act, high_act, phase_act;
      logic [W-1:0] div_sh, high_sh, phase_sh;
      logic [W-1:0] cnt_q;
      logic [W-1:0] ld_high, ld_phase;
      logic         pend_q, clk_q, wr, wrap, apply;

      assign wr       = accept && (cfg_ch == CHW'(i));
      assign wrap     = (cnt_q == div_act - W'(1));
      assign apply    = pend_q && (!ch_en[i] || sync_rst || wrap);
      assign ld_high  = pend_q ? high_sh  : high_act;
      assign ld_phase = pend_q ? phase_sh : phase_act;

      // Restart paths load the settings that will be active after this edge, so a
      // freshly applied phase can never leave the counter beyond the new divide ratio.
      always_ff @(posedge clk or posedge phase_rst) begin
         if (phase_rst) begin
            div_act   <= RST_DIV;
            high_act  <= RST_HIGH;
            phase_act <= '0;
            div_sh    <= RST_DIV;
            high_sh   <= RST_HIGH;
            phase_sh  <= '0;
            pend_q    <= 1'b0;
            cnt_q     <= '0;
            clk_q     <= 1'b0;
         end else begin
            if (!ch_en[i]) begin
               cnt_q <= ld_phase;
               clk_q <= 1'b0;
            end else if (sync_rst) begin
               cnt_q <= ld_phase;
               clk_q <= (ld_phase < ld_high);
            end else if (wrap) begin
               cnt_q <= '0;
               clk_q <= 1'b1;
            end else begin
               cnt_q <= cnt_q + W'(1);
               clk_q <= ((cnt_q + W'(1)) < high_act);
            end

            if (apply) begin
               div_act   <= div_sh;
               high_act  <= high_sh;
               phase_act <= phase_sh;
            end

            // A write is only accepted with pend_q clear, so it never races an apply.
            if (wr) begin
               div_sh   <= cfg_div;
               high_sh  <= cfg_high;
               phase_sh <= cfg_phase;
               pend_q   <= 1'b1;
            end else if (apply) begin
               pend_q <= 1'b0;
            end
         end
      end

`ifdef CLKDIV_STROBE_EN
      logic strobe_q;

      always_ff @(posedge clk or posedge phase_rst) begin
         if (phase_rst) strobe_q <= 1'b0;
         else           strobe_q <= ch_en[i] && !sync_rst && wrap;
      end

      assign strobe[i] = strobe_q;
`endif

      assign pending[i]       = pend_q;
      assign clk_div[i]       = clk_q;
      assign cnt[i*W +: W]    = cnt_q;
   end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi: defaults, retune, reject, phase
// alignment, wrap-cycle config and async reset with a pending shadow.
module tb_clk_div_multi;

   localparam int CH      = 4;
   localparam int W       = 32;
   localparam int CHW     = 2;
   localparam int DEF_DIV = 1000;

   logic            clk       = 1'b0;
   logic            phase_rst = 1'b1;
   logic            sync_rst  = 1'b0;
   logic [CH-1:0]   ch_en     = '0;
   logic            cfg_valid = 1'b0;
   logic            cfg_ready;
   logic [CHW-1:0]  cfg_ch    = '0;
   logic [W-1:0]    cfg_div   = '0;
   logic [W-1:0]    cfg_high  = '0;
   logic [W-1:0]    cfg_phase = '0;
   logic            cfg_err;
   logic [CH-1:0]   clk_div;
   logic [CH*W-1:0] cnt;
`ifdef CLKDIV_STROBE_EN
   logic [CH-1:0]   strobe;
`endif

   int checks   = 0;
   int failures = 0;

   clk_div_multi #(.CH(CH), .W(W), .CHW(CHW), .DEF_DIV(DEF_DIV)) dut (
      .clk       (clk),
      .phase_rst (phase_rst),
      .sync_rst  (sync_rst),
      .ch_en     (ch_en),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .cfg_high  (cfg_high),
      .cfg_phase (cfg_phase),
      .cfg_err   (cfg_err),
      .clk_div   (clk_div),
      .cnt       (cnt)
`ifdef CLKDIV_STROBE_EN
      ,
      .strobe    (strobe)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] cntOf(input int i);
      return cnt[i*W +: W];
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Holds cfg_valid until the channel is ready (bounded), then transfers on one edge.
   task automatic applyStimulus(input int ch, input logic [W-1:0] d, input logic [W-1:0] h,
                                input logic [W-1:0] p, output int waits);
      cfg_ch    = CHW'(ch);
      cfg_div   = d;
      cfg_high  = h;
      cfg_phase = p;
      cfg_valid = 1'b1;
      #1;
      waits = 0;
      while (!cfg_ready && waits < 3000) begin
         tick();
         waits++;
      end
      if (!cfg_ready) checkOutput("cfg_ready_timeout", 64'(cfg_ready), 1);
      tick();
      cfg_valid = 1'b0;
   endtask

   // Ch0 starts from cnt=0 with default settings: high for cnt 0..499, low for 500..999.
   task automatic runDefaultPeriod(input string tag);
      int highs   = 0;
      int strobes = 0;
      for (int k = 1; k <= 1000; k++) begin
         tick();
         if (clk_div[0]) highs++;
`ifdef CLKDIV_STROBE_EN
         if (strobe[0]) strobes++;
`endif
         if (k == 1) begin
            checkOutput({tag, "_cnt_first"}, cntOf(0), 1);
            checkOutput({tag, "_clk_first"}, clk_div[0], 1);
         end
         if (k == 500) begin
            checkOutput({tag, "_cnt500"}, cntOf(0), 500);
            checkOutput({tag, "_clk500"}, clk_div[0], 0);
         end
      end
      checkOutput({tag, "_wrap_cnt"}, cntOf(0), 0);
      checkOutput({tag, "_wrap_clk"}, clk_div[0], 1);
      checkOutput({tag, "_high_cycles"}, highs, 500);
`ifdef CLKDIV_STROBE_EN
      checkOutput({tag, "_strobes"}, strobes, 1);
      checkOutput({tag, "_strobe_wrap"}, strobe[0], 1);
`endif
      checkOutput({tag, "_idle_cnt"}, 64'(cnt[CH*W-1:W]), 0);
      checkOutput({tag, "_idle_clk"}, clk_div[CH-1:1], 0);
   endtask

   initial begin
      int waits;
      int highs;
      int rise [CH];
      logic [CH-1:0] prev;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_cnt_zero", |cnt, 0);
      checkOutput("rst_clk_div", clk_div, 0);
      checkOutput("rst_cfg_err", cfg_err, 0);
      checkOutput("rst_cfg_ready", cfg_ready, 1);

      #2;
      phase_rst = 1'b0;
      ch_en     = 4'b0001;
      runDefaultPeriod("def");

      repeat (100) tick();
      checkOutput("retune_cnt_before", cntOf(0), 100);
      applyStimulus(0, 10, 3, 0, waits);
      checkOutput("retune_accept_wait", waits, 0);
      checkOutput("retune_ready_low", cfg_ready, 0);
      checkOutput("retune_cnt_after", cntOf(0), 101);
      waits = 0;
      while (!cfg_ready && waits < 2000) begin
         tick();
         waits++;
      end
      checkOutput("retune_apply_wait", waits, 899);
      checkOutput("retune_apply_cnt", cntOf(0), 0);
      checkOutput("retune_apply_clk", clk_div[0], 1);
      highs = 0;
      repeat (10) begin
         tick();
         if (clk_div[0]) highs++;
      end
      checkOutput("retune_high_cycles", highs, 3);
      checkOutput("retune_period_cnt", cntOf(0), 0);

      applyStimulus(1, 1, 1, 0, waits);
      checkOutput("rej_div1_err", cfg_err, 1);
      checkOutput("rej_div1_ready", cfg_ready, 1);
      tick();
      checkOutput("rej_div1_err_clear", cfg_err, 0);
      applyStimulus(1, 8, 8, 0, waits);
      checkOutput("rej_high_err", cfg_err, 1);
      checkOutput("rej_high_ready", cfg_ready, 1);
      tick();
      checkOutput("rej_high_err_clear", cfg_err, 0);
      ch_en = 4'b0011;
      repeat (10) tick();
      checkOutput("rej_ch1_cnt", cntOf(1), 10);
      checkOutput("rej_ch1_clk", clk_div[1], 1);

      ch_en = 4'b0000;
      for (int i = 0; i < CH; i++) applyStimulus(i, 8, 4, W'(2 * i), waits);
      ch_en    = 4'b1111;
      sync_rst = 1'b1;
      tick();
      sync_rst = 1'b0;
      for (int i = 0; i < CH; i++) checkOutput($sformatf("sync_cnt%0d", i), cntOf(i), 2 * i);
      checkOutput("sync_clk_div", clk_div, 4'b0011);
`ifdef CLKDIV_STROBE_EN
      checkOutput("sync_strobe", strobe, 0);
`endif
      prev = clk_div;
      for (int i = 0; i < CH; i++) rise[i] = -1;
      for (int t = 1; t <= 10; t++) begin
         tick();
         for (int i = 0; i < CH; i++)
            if (clk_div[i] && !prev[i] && rise[i] < 0) rise[i] = t;
         prev = clk_div;
      end
      for (int i = 0; i < CH; i++) checkOutput($sformatf("sync_rise%0d", i), rise[i], 8 - 2 * i);

      waits = 0;
      while (cntOf(2) != 7 && waits < 20) begin
         tick();
         waits++;
      end
      checkOutput("bnd_pre_wrap_cnt", cntOf(2), 7);
      applyStimulus(2, 4, 1, 0, waits);
      checkOutput("bnd_wrap_cnt", cntOf(2), 0);
      checkOutput("bnd_wrap_clk", clk_div[2], 1);
      checkOutput("bnd_wrap_ready", cfg_ready, 0);
      repeat (7) tick();
      checkOutput("bnd_old_cnt", cntOf(2), 7);
      checkOutput("bnd_old_clk", clk_div[2], 0);
      checkOutput("bnd_old_ready", cfg_ready, 0);
      tick();
      checkOutput("bnd_apply_cnt", cntOf(2), 0);
      checkOutput("bnd_apply_ready", cfg_ready, 1);
      highs = 0;
      repeat (4) begin
         tick();
         if (clk_div[2]) highs++;
      end
      checkOutput("bnd_new_highs", highs, 1);
      checkOutput("bnd_new_cnt", cntOf(2), 0);
      applyStimulus(2, 6, 2, 1, waits);
      checkOutput("bnd_first_wait", waits, 0);
      applyStimulus(2, 8, 4, 0, waits);
      checkOutput("bnd_stall_wait", waits, 3);
      checkOutput("bnd_stall_cnt", cntOf(2), 1);
      checkOutput("bnd_stall_clk", clk_div[2], 1);
      checkOutput("bnd_stall_ready", cfg_ready, 0);

      #2;
      phase_rst = 1'b1;
      #1;
      checkOutput("arst_cnt_zero", |cnt, 0);
      checkOutput("arst_clk_div", clk_div, 0);
      checkOutput("arst_cfg_err", cfg_err, 0);
      checkOutput("arst_ready", cfg_ready, 1);
`ifdef CLKDIV_STROBE_EN
      checkOutput("arst_strobe", strobe, 0);
`endif
      phase_rst = 1'b0;
      ch_en     = 4'b0001;
      runDefaultPeriod("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
